// File: rtl/host_seq_pkg.sv
// Shared definitions for the host sequencer: run-state encoding, default
// memory map / timeout, and the byte-address helper.
package host_seq_pkg;

  localparam logic [7:0]  DEFAULT_IN_ADDR  = 8'd0;
  localparam logic [7:0]  DEFAULT_OUT_ADDR = 8'd2;
  localparam logic [15:0] DEFAULT_TIMEOUT  = 16'd4096;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    WR_LO     = 4'd1,
    WR_HI     = 4'd2,
    START     = 4'd3,
    WAIT_DONE = 4'd4,
    RD_LO     = 4'd5,
    RD_HI     = 4'd6,
    RD_CAP    = 4'd7,
    RESP      = 4'd8
  } state_e;

  // Low/high byte address of a 16-bit word; wraps modulo 256 by construction.
  function automatic logic [7:0] byte_addr(input logic [7:0] base, input logic hi);
    return base + {7'd0, hi};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
// count_next is exposed so the owner can act on the value being loaded.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Next count: clear wins, then saturating increment.
  always_comb begin
    count_next = count;
    if (clr) begin
      count_next = '0;
    end else if (en && (count != CNT_MAX)) begin
      count_next = count + CNT_ONE;
    end else begin
      count_next = count;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/host_sequencer.sv
// Host-side run sequencer: writes an operand into CPU data memory, pulses
// start, waits (bounded) for done, reads the result back and offers it.
module host_sequencer
  import host_seq_pkg::*;
#(
  parameter logic [7:0]  IN_ADDR  = DEFAULT_IN_ADDR,
  parameter logic [7:0]  OUT_ADDR = DEFAULT_OUT_ADDR,
  parameter logic [15:0] TIMEOUT  = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        start,
  input  logic        done,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_timeout,
  output logic [15:0] out_cycles
);

  state_e      state_r;
  state_e      state_s;
  logic [7:0]  operand_hi_r;
  logic        armed_r;
  logic        accept_s;
  logic        done_take_s;
  logic        timeout_hit_s;
  logic        cnt_clr_s;
  logic        cnt_en_s;
  logic [15:0] cnt_next_s;
  logic [7:0]  addr_s;
  logic [7:0]  wdata_s;

  assign accept_s      = (state_r == IDLE) && in_valid && in_ready;
  assign done_take_s   = (state_r == WAIT_DONE) && armed_r && done;
  assign timeout_hit_s = (state_r == WAIT_DONE) && (cnt_next_s >= TIMEOUT);
  assign cnt_clr_s     = (state_r == START);
  assign cnt_en_s      = (state_r == WAIT_DONE);

  sat_counter #(.WIDTH(16)) u_cycles (
    .clk        (clk),
    .rst_n      (reset),
    .clr        (cnt_clr_s),
    .en         (cnt_en_s),
    .count      (out_cycles),
    .count_next (cnt_next_s)
  );

  // Run sequencing; completion beats timeout when both land on the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:      if (accept_s) state_s = WR_LO; else state_s = IDLE;
      WR_LO:     state_s = WR_HI;
      WR_HI:     state_s = START;
      START:     state_s = WAIT_DONE;
      WAIT_DONE: begin
        if (done_take_s) begin
          state_s = RD_LO;
        end else if (timeout_hit_s) begin
          state_s = RESP;
        end else begin
          state_s = WAIT_DONE;
        end
      end
      RD_LO:     state_s = RD_HI;
      RD_HI:     state_s = RD_CAP;
      RD_CAP:    state_s = RESP;
      RESP:      if (out_ready) state_s = IDLE; else state_s = RESP;
      default:   state_s = IDLE;
    endcase
  end

  // Memory bus decode for the state being entered, so the bus is registered.
  always_comb begin
    addr_s  = 8'h00;
    wdata_s = 8'h00;
    case (state_s)
      WR_LO: begin
        addr_s  = byte_addr(IN_ADDR, 1'b0);
        wdata_s = in_data[7:0];
      end
      WR_HI: begin
        addr_s  = byte_addr(IN_ADDR, 1'b1);
        wdata_s = operand_hi_r;
      end
      RD_LO:   addr_s = byte_addr(OUT_ADDR, 1'b0);
      RD_HI:   addr_s = byte_addr(OUT_ADDR, 1'b1);
      default: begin
        addr_s  = 8'h00;
        wdata_s = 8'h00;
      end
    endcase
  end

  // Operand latch and armed flag (armed only after done has been seen low).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      operand_hi_r <= 8'h00;
      armed_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        operand_hi_r <= in_data[15:8];
      end else begin
        operand_hi_r <= operand_hi_r;
      end
      if (state_r == START) begin
        armed_r <= 1'b0;
      end else if ((state_r == WAIT_DONE) && !done) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  // State, registered control outputs and result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      in_ready    <= 1'b1;
      start       <= 1'b0;
      out_valid   <= 1'b0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      mem_addr    <= 8'h00;
      mem_wdata   <= 8'h00;
      out_data    <= 16'h0000;
      out_timeout <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      start     <= (state_s == START);
      out_valid <= (state_s == RESP);
      mem_we    <= (state_s == WR_LO) || (state_s == WR_HI);
      mem_re    <= (state_s == RD_LO) || (state_s == RD_HI);
      mem_addr  <= addr_s;
      mem_wdata <= wdata_s;
      if (accept_s) begin
        out_data <= 16'h0000;
      end else if (state_r == RD_HI) begin
        out_data[7:0] <= mem_rdata;
      end else if (state_r == RD_CAP) begin
        out_data[15:8] <= mem_rdata;
      end else begin
        out_data <= out_data;
      end
      if (accept_s) begin
        out_timeout <= 1'b0;
      end else if (timeout_hit_s && !done_take_s) begin
        out_timeout <= 1'b1;
      end else begin
        out_timeout <= out_timeout;
      end
    end
  end

endmodule

// File: tb/tb_host_sequencer.sv
// Randomized bench: two sequencers (default map, and wrapped map with a short
// timeout) driven against a CPU/memory model and a run-level expectation model.
module tb_host_sequencer;
  import host_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid    [2];
  logic [15:0] in_data     [2];
  logic        in_ready    [2];
  logic        start       [2];
  logic        done        [2];
  logic        mem_we      [2];
  logic        mem_re      [2];
  logic [7:0]  mem_addr    [2];
  logic [7:0]  mem_wdata   [2];
  logic [7:0]  mem_rdata   [2];
  logic        out_valid   [2];
  logic        out_ready   [2];
  logic [15:0] out_data    [2];
  logic        out_timeout [2];
  logic [15:0] out_cycles  [2];

  logic [7:0]  mem [2][256];
  int          cnt [2];
  bit          active [2];
  int          drop_cfg [2];
  int          delay_cfg [2];
  logic [15:0] key_cfg [2];
  logic [15:0] cpu_op [2];
  logic [15:0] cpu_res [2];
  int          n_start [2];
  int          n_re [2];
  int          n_viol [2];
  int          n_cmp;
  int          n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  host_sequencer u_dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .start(start[0]), .done(done[0]), .mem_we(mem_we[0]),
    .mem_re(mem_re[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_timeout(out_timeout[0]), .out_cycles(out_cycles[0])
  );

  host_sequencer #(.IN_ADDR(8'hFF), .OUT_ADDR(8'h10), .TIMEOUT(16'd16)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .start(start[1]), .done(done[1]), .mem_we(mem_we[1]),
    .mem_re(mem_re[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_timeout(out_timeout[1]), .out_cycles(out_cycles[1])
  );

  function automatic logic [7:0] lane_in(input int l);
    return (l == 0) ? DEFAULT_IN_ADDR : 8'hFF;
  endfunction
  function automatic logic [7:0] lane_out(input int l);
    return (l == 0) ? DEFAULT_OUT_ADDR : 8'h10;
  endfunction
  function automatic logic [7:0] next_byte(input logic [7:0] a);
    logic [7:0] n;
    n = a + 8'd1;
    return n;
  endfunction
  function automatic int lane_timeout(input int l);
    return (l == 0) ? int'(DEFAULT_TIMEOUT) : 16;
  endfunction

  // Data memory, CPU (result = operand ^ key, done N edges after start seen), bus monitor.
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (mem_we[l] && mem_re[l]) n_viol[l]++;
      if (!mem_we[l] && !mem_re[l] && (mem_addr[l] != 8'h00 || mem_wdata[l] != 8'h00)) n_viol[l]++;
      if (mem_re[l]) n_re[l]++;
      if (start[l]) n_start[l]++;
      if (mem_we[l]) mem[l][mem_addr[l]] <= mem_wdata[l];
      mem_rdata[l] <= mem_re[l] ? mem[l][mem_addr[l]] : 8'($urandom);
      if (!reset) begin
        done[l]   <= 1'b0;
        active[l] = 1'b0;
      end else if (start[l]) begin
        cpu_op[l]  = {mem[l][next_byte(lane_in(l))], mem[l][lane_in(l)]};
        cpu_res[l] = cpu_op[l] ^ key_cfg[l];
        mem[l][lane_out(l)]            <= cpu_res[l][7:0];
        mem[l][next_byte(lane_out(l))] <= cpu_res[l][15:8];
        cnt[l]    = 0;
        active[l] = 1'b1;
        if (drop_cfg[l] == 0) done[l] <= 1'b0;
      end else if (active[l]) begin
        cnt[l]++;
        if (cnt[l] == drop_cfg[l]) done[l] <= 1'b0;
        if (cnt[l] == delay_cfg[l]) begin
          done[l]   <= 1'b1;
          active[l] = 1'b0;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer an operand; returns just after the handshake edge.
  task automatic send_op(input int l, input logic [15:0] op);
    int w;
    w = 0;
    while (in_ready[l] !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check_eq("in_ready_idle", {31'd0, in_ready[l]}, 32'd1);
    in_valid[l] = 1'b1;
    in_data[l]  = op;
    @(posedge clk);
    #1;
    in_valid[l] = 1'b0;
    in_data[l]  = 16'($urandom);
  endtask

  // One full run; delay<0 means the CPU never finishes.
  task automatic run_op(input int l, input logic [15:0] op, input int drop, input int delay,
                        input int hold, input logic [15:0] key);
    int          lat;
    int          tlim;
    int          b_start;
    int          b_re;
    int          b_viol;
    bit          tmo;
    logic [15:0] res_exp;
    logic [15:0] cyc_exp;
    drop_cfg[l]  = drop;
    delay_cfg[l] = delay;
    key_cfg[l]   = key;
    b_start = n_start[l];
    b_re    = n_re[l];
    b_viol  = n_viol[l];
    tlim    = lane_timeout(l);
    tmo     = (delay < 0) || (delay + 1 > tlim);
    cyc_exp = tmo ? 16'(tlim) : 16'(delay + 1);
    res_exp = tmo ? 16'h0000 : (op ^ key);
    send_op(l, op);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (start[l] !== 1'b1 && lat < 10);
    check_eq("start_latency", lat, 32'd3);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (out_valid[l] !== 1'b1 && lat < tlim + 40);
    check_eq("resp_latency", lat, tmo ? tlim + 1 : delay + 5);
    for (int h = 0; h <= hold; h++) begin
      check_eq("resp_hold", {13'd0, out_valid[l], in_ready[l], out_timeout[l], out_data[l]},
               {13'd0, 1'b1, 1'b0, tmo, res_exp});
      check_eq("resp_cycles", {16'd0, out_cycles[l]}, {16'd0, cyc_exp});
      if (h < hold) @(negedge clk);
    end
    out_ready[l] = 1'b1;
    @(negedge clk);
    out_ready[l] = 1'b0;
    check_eq("return_idle", {30'd0, out_valid[l], in_ready[l]}, 32'd1);
    check_eq("mem_written", {16'd0, mem[l][next_byte(lane_in(l))], mem[l][lane_in(l)]}, {16'd0, op});
    check_eq("start_pulses", n_start[l] - b_start, 32'd1);
    check_eq("mem_reads", n_re[l] - b_re, tmo ? 32'd0 : 32'd2);
    check_eq("bus_protocol", n_viol[l] - b_viol, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int rl;
    int rdrop;
    int rdelay;
    int b_start;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    for (int l = 0; l < 2; l++) begin
      in_valid[l]  = 1'b0;
      in_data[l]   = 16'h0000;
      out_ready[l] = 1'b0;
      drop_cfg[l]  = 0;
      delay_cfg[l] = -1;
      key_cfg[l]   = 16'h0000;
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check_eq("reset_ctrl", {11'd0, start[l], mem_we[l], mem_re[l], out_valid[l], out_timeout[l],
                              mem_addr[l], mem_wdata[l]}, 32'd0);
      check_eq("reset_data", {out_data[l], out_cycles[l]}, 32'd0);
      check_eq("reset_in_ready", {31'd0, in_ready[l]}, 32'd1);
    end

    run_op(0, 16'h1234, 0, 20, 0, 16'h0000);
    run_op(0, 16'h4321, 2, 12, 0, 16'h0000);
    run_op(0, 16'hC3C3, 0, 5, 5, 16'h00FF);
    run_op(1, 16'h7E7E, 0, -1, 2, 16'h0000);
    run_op(1, 16'h0001, 1, 15, 0, 16'hFFFF);
    run_op(1, 16'hA55A, 0, 9, 0, 16'h0000);

    drop_cfg[0]  = 0;
    delay_cfg[0] = -1;
    send_op(0, 16'h0F0F);
    repeat (8) @(negedge clk);
    check_eq("wait_cycles", {16'd0, out_cycles[0]}, 32'd4);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_reset_ctrl", {11'd0, start[0], mem_we[0], mem_re[0], out_valid[0], out_timeout[0],
                                  mem_addr[0], mem_wdata[0]}, 32'd0);
    check_eq("async_reset_data", {out_data[0], out_cycles[0]}, 32'd0);
    @(negedge clk);
    reset   = 1'b1;
    b_start = n_start[0];
    repeat (10) @(negedge clk);
    check_eq("post_reset_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check_eq("post_reset_no_start", n_start[0] - b_start, 32'd0);
    run_op(0, 16'hBEEF, 0, 7, 1, 16'h0000);

    for (int i = 0; i < 24; i++) begin
      rl     = int'($urandom_range(1, 0));
      rdrop  = int'($urandom_range(3, 0));
      rdelay = rdrop + int'($urandom_range(25, 1));
      if (rl == 1 && $urandom_range(5, 0) == 0) rdelay = -1;
      run_op(rl, 16'($urandom), rdrop, rdelay, int'($urandom_range(4, 0)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/host_sequencer.md
HOST_SEQUENCER -- requirements
Module: host_sequencer

Interface
REQ-001 SHALL have parameter IN_ADDR, default 8'd0, data-memory byte address of the operand low byte; the high byte is at IN_ADDR+1.
REQ-002 SHALL have parameter OUT_ADDR, default 8'd2, data-memory byte address of the result low byte; the high byte is at OUT_ADDR+1.
REQ-003 SHALL have parameter TIMEOUT, default 16'd4096, the maximum number of cycles spent waiting for done.
REQ-004 Ports SHALL be exactly as follows:
clk  input  1  single clock; all logic on posedge
reset  input  1  asynchronous, active-low
in_valid  input  1  operand offered
in_data  input  16  operand
in_ready  output  1  operand accepted when in_valid&&in_ready
start  output  1  one-cycle start pulse to the CPU
done  input  1  CPU completion level
mem_we  output  1  data-memory byte write enable
mem_re  output  1  data-memory byte read enable
mem_addr  output  8  data-memory byte address
mem_wdata  output  8  write byte
mem_rdata  input  8  read byte, valid one cycle after mem_re
out_valid  output  1  result available
out_ready  input  1  result consumed when out_valid&&out_ready
out_data  output  16  {high byte, low byte} read back
out_timeout  output  1  run ended by timeout; out_data is then 16'h0000
out_cycles  output  16  cycles counted in WAIT_DONE

Function
REQ-005 FSM states SHALL be IDLE, WR_LO, WR_HI, START, WAIT_DONE, RD_LO, RD_HI, RD_CAP, RESP.
REQ-006 in_ready SHALL be 1 only in IDLE; a handshake latches in_data and moves the FSM to WR_LO.
REQ-007 In WR_LO: mem_we=1, mem_addr=IN_ADDR, mem_wdata=operand[7:0].
REQ-008 In WR_HI: mem_we=1, mem_addr=IN_ADDR+1, mem_wdata=operand[15:8].
REQ-009 In START, start SHALL be 1 for exactly one cycle; start SHALL be 0 in every other state.
REQ-010 WAIT_DONE SHALL use an armed flag, cleared on entry and set on the first cycle with done==0.
REQ-011 done==1 SHALL be honoured only when armed, which prevents a stale done from a prior run being taken as completion.
REQ-012 In WAIT_DONE, out_cycles SHALL increment every cycle and saturate at 16'hFFFF.
REQ-013 WAIT_DONE SHALL go to RD_LO on armed&&done.
REQ-014 WAIT_DONE SHALL go to RESP with out_timeout=1 when the cycle count reaches TIMEOUT without armed&&done.
REQ-015 If armed&&done and the timeout coincide, done SHALL win.
REQ-016 In RD_LO: mem_re=1, mem_addr=OUT_ADDR.
REQ-017 In RD_HI: mem_re=1, mem_addr=OUT_ADDR+1, and out_data[7:0] captures mem_rdata.
REQ-018 In RD_CAP, out_data[15:8] SHALL capture mem_rdata.
REQ-019 RD_CAP SHALL go to RESP.
REQ-020 In RESP, out_valid SHALL be 1 and out_data, out_timeout and out_cycles SHALL be held stable until out_ready.
REQ-021 On out_valid&&out_ready the FSM SHALL return to IDLE; there is no back-to-back acceptance in the same cycle.
REQ-022 mem_we and mem_re SHALL never both be 1; in states where they are inactive, mem_addr and mem_wdata SHALL be 0.
REQ-023 Address arithmetic SHALL be 8-bit and wrap modulo 256, so IN_ADDR=8'hFF places the high byte at 8'h00.
REQ-024 Latency from operand handshake to first start=1 SHALL be 3 cycles.
REQ-025 Latency from the accepted done edge to out_valid SHALL be 4 cycles.

Reset
REQ-026 reset low SHALL immediately force IDLE regardless of state, including mid-run.
REQ-027 reset low SHALL force all outputs to 0 except in_ready, which SHALL be 1 after reset deasserts.
REQ-028 reset low SHALL clear out_data, out_cycles, out_timeout, the armed flag and the latched operand.
REQ-029 A reset asserted during WAIT_DONE SHALL NOT issue a further start pulse; the run is abandoned.

Structure
REQ-030 The state enum and the DEFAULT_TIMEOUT, DEFAULT_IN_ADDR and DEFAULT_OUT_ADDR constants SHALL live in shared package host_seq_pkg.
REQ-031 A saturating cycle counter with clear and enable SHALL be the single sub-module, named sat_counter.

Verification
REQ-032 Operand 16'h1234 with a memory model that copies mem[0..1] to mem[2..3] and raises done 20 cycles after start -> mem[1]=8'h12, mem[0]=8'h34, out_data=16'h1234, out_timeout=0, out_cycles=21.
REQ-033 done held high from before start and dropped 2 cycles after start, then raised 10 cycles later -> no early completion; exactly one start pulse; out_cycles=13.
REQ-034 done never asserts with TIMEOUT=16 -> RESP after 16 WAIT_DONE cycles with out_timeout=1, out_data=16'h0000, and no memory reads.
REQ-035 out_ready held low 5 cycles in RESP -> out_valid and out_data stable; in_ready=0 throughout; IDLE one cycle after the handshake.
REQ-036 reset pulsed low during WAIT_DONE -> outputs 0 asynchronously, in_ready=1 after release, and a new operand 16'hBEEF completes correctly.
REQ-037 IN_ADDR=8'hFF, operand 16'hA55A -> writes 8'h5A at 8'hFF and 8'hA5 at 8'h00.
